// File: rtl/wb2axip_sfifo_wrarb.sv
// wb2axip_sfifo_wrarb: round-robin burst arbiter merging requesters into one synchronous FIFO
module wb2axip_sfifo_wrarb #(
  parameter int LGNIN = 2,
  parameter int BW = 8,
  parameter int LGBURST = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [(1<<LGNIN)-1:0]     i_valid,
  input  logic [(1<<LGNIN)*BW-1:0]  i_data,
  output logic [(1<<LGNIN)-1:0]     o_ready,
  output logic                      o_fifo_wr,
  output logic [LGNIN+BW-1:0]       o_fifo_data,
  input  logic                      i_fifo_full,
  output logic [(1<<LGNIN)-1:0]     o_grant,
  output logic                      o_busy
);
  localparam int NIN = 1 << LGNIN;
  localparam logic IDLE = 1'b0;
  localparam logic GRANT = 1'b1;
  logic state, xfer;
  logic [LGNIN-1:0] rr, gi, sel, idx;
  logic [LGBURST-1:0] beat;
  assign xfer = state == GRANT && !i_reset && i_valid[gi] && !i_fifo_full;
  assign o_ready = (state == GRANT && !i_reset && !i_fifo_full) ? o_grant : '0;
  assign o_fifo_wr = xfer;
  assign o_fifo_data = xfer ? {gi, i_data[gi*BW +: BW]} : '0;
  assign o_busy = state == GRANT && !i_reset;
  // first valid requester at or after the round-robin pointer
  always_comb begin
    sel = rr;
    idx = rr;
    for (int k = NIN-1; k >= 0; k--) begin
      idx = rr + LGNIN'(k);
      if (i_valid[idx]) sel = idx;
    end
  end
  // arbitrate in IDLE, hold the grant for up to a full burst, release on last beat or dropped valid
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      rr <= '0;
      gi <= '0;
      beat <= '0;
      o_grant <= '0;
    end else if (state == IDLE) begin
      if (|i_valid) begin
        state <= GRANT;
        gi <= sel;
        beat <= '0;
        o_grant <= NIN'(1) << sel;
      end
    end else if (!i_valid[gi] || (xfer && &beat)) begin
      state <= IDLE;
      rr <= gi + 1'b1;
      o_grant <= '0;
    end else if (xfer) begin
      beat <= beat + 1'b1;
    end
  end
endmodule
